// File: rtl/sc_stream_decoder_if.sv
// Stream-decoder bus: frame request, per-pixel bitstreams in, per-pixel ones counts out.
interface sc_stream_decoder_if #(
  parameter int m  = 32,
  parameter int n  = 32,
  parameter int CW = 9
);
  logic          start;
  logic          s       [0:m*n-1];
  logic          busy;
  logic          done;
  logic          valid;
  logic [CW-1:0] pix_out [0:m*n-1];

  modport master (output start, s, input busy, done, valid, pix_out);
  modport slave  (input start, s, output busy, done, valid, pix_out);
endinterface

// File: rtl/sc_stream_decoder.sv
// Stochastic-computing stream decoder: counts ones per pixel over a fixed-length
// bitstream window after a warm-up flush, then publishes the frame.
module sc_stream_decoder #(
  parameter int m          = 32,
  parameter int n          = 32,
  parameter int STREAM_LEN = 256,
  parameter int WARMUP     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sc_stream_decoder_if.slave   bus
);
  localparam int unsigned NPIX    = m * n;
  localparam int unsigned CW      = $clog2(STREAM_LEN) + 1;
  localparam int unsigned CNT_MAX = (WARMUP > STREAM_LEN) ? WARMUP : STREAM_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, WARM, ACCUM, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            w_clr;
  logic [CNT_W-1:0] r_cnt;
  logic [CW-1:0]   r_acc [0:NPIX-1];
  logic [CW-1:0]   r_pix [0:NPIX-1];
  logic            r_busy;
  logic            r_done;
  logic            r_valid;

  // Last row and last column have no upstream edge detector.
  function automatic logic is_border(input int k);
    return ((k / n) == (m - 1)) || ((k % n) == (n - 1));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_clr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_clr      = 1'b1;
          w_state_nx = (WARMUP == 0) ? ACCUM : WARM;
        end
      end
      WARM:    if (r_cnt == CNT_W'(WARMUP - 1))     w_state_nx = ACCUM;
      ACCUM:   if (r_cnt == CNT_W'(STREAM_LEN - 1)) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Phase counter restarts on every state change, so it counts cycles within WARM/ACCUM.
  always_ff @(posedge clk) begin
    if (reset || (w_state_nx != r_state)) r_cnt <= '0;
    else if ((r_state == WARM) || (r_state == ACCUM)) r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NPIX); k++) begin
      if (reset || w_clr || is_border(k)) r_acc[k] <= '0;
      else if (r_state == ACCUM)          r_acc[k] <= r_acc[k] + CW'(bus.s[k]);
    end
  end

  // Results are published only when leaving DONE; an aborted frame never reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_pix   <= '{default: '0};
    end else begin
      r_busy <= (w_state_nx != IDLE);
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_valid <= 1'b1;
        r_pix   <= r_acc;
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.valid   = r_valid;
  assign bus.pix_out = r_pix;
endmodule
